// File: rtl/maxp_ctrl_pkg.sv
// Shared constants and FSM state encoding for the max-pool sequencer.
// MAXP_CTRL_FAIR_EN adds the REL state used to drop the memory request at row ends.
package maxp_ctrl_pkg;

  localparam int MEM_SIZE  = 16;
  localparam int DATA_SIZE = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
`ifdef MAXP_CTRL_FAIR_EN
    , S_REL = 3'd5
`endif
  } state_t;

endpackage

// File: rtl/maxp_ctrl_if.sv
// Job, feature-memory read port and maxp_unit control bundle.
// master = sequencer side, slave = scheduler/arbiter/maxp_unit side.
interface maxp_ctrl_if #(
  parameter int DIM_SIZE = 8
);
  import maxp_ctrl_pkg::*;

  logic                start;
  logic [MEM_SIZE-1:0] cfg_src;
  logic [MEM_SIZE-1:0] cfg_dst;
  logic [DIM_SIZE-1:0] cfg_w;
  logic [DIM_SIZE-1:0] cfg_h;
  logic                busy;
  logic                done;
  logic                mem_req;
  logic                mem_gnt;
  logic                mem_re;
  logic [MEM_SIZE-1:0] mem_ra;
  logic                mp_en;
  logic                mp_we;
  logic [MEM_SIZE-1:0] mp_wa;

  modport master (
    input  start, cfg_src, cfg_dst, cfg_w, cfg_h, mem_gnt,
    output busy, done, mem_req, mem_re, mem_ra, mp_en, mp_we, mp_wa
  );

  modport slave (
    output start, cfg_src, cfg_dst, cfg_w, cfg_h, mem_gnt,
    input  busy, done, mem_req, mem_re, mem_ra, mp_en, mp_we, mp_wa
  );

endinterface

// File: rtl/maxp_ctrl_addr_gen.sv
// Window/row/column walker: read address = row pointer + column pointer,
// destination address from an incrementing counter; no multipliers.
module maxp_addr_gen
  import maxp_ctrl_pkg::*;
#(
  parameter int POOL     = 2,
  parameter int DIM_SIZE = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                step,
  input  logic [MEM_SIZE-1:0] cfg_src,
  input  logic [MEM_SIZE-1:0] cfg_dst,
  input  logic [DIM_SIZE-1:0] cfg_w,
  input  logic [DIM_SIZE-1:0] cfg_h,
  output logic [MEM_SIZE-1:0] rd_addr,
  output logic [MEM_SIZE-1:0] wr_addr,
  output logic                last_elem,
  output logic                last_win_row,
  output logic                last_win
);

  localparam int                 KW     = (POOL > 1) ? $clog2(POOL) : 1;
  localparam logic [KW-1:0]      K_LAST = KW'(POOL - 1);
  localparam logic [MEM_SIZE-1:0] K_BACK = MEM_SIZE'(POOL - 1);

  logic [KW-1:0]       c_q, r_q;
  logic [DIM_SIZE-1:0] ox_q, oy_q, ow_last_q, oh_last_q;
  logic [MEM_SIZE-1:0] w_q, row_q, win_row_q, col_q, dst_q;

  assign rd_addr      = row_q + col_q;
  assign wr_addr      = dst_q;
  assign last_elem    = (c_q == K_LAST) && (r_q == K_LAST);
  assign last_win_row = last_elem && (ox_q == ow_last_q);
  assign last_win     = last_win_row && (oy_q == oh_last_q);

  // row_q tracks the start of the current element row, win_row_q the first
  // element row of the current row of windows.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_q       <= '0;
      r_q       <= '0;
      ox_q      <= '0;
      oy_q      <= '0;
      ow_last_q <= '0;
      oh_last_q <= '0;
      w_q       <= '0;
      row_q     <= '0;
      win_row_q <= '0;
      col_q     <= '0;
      dst_q     <= '0;
    end else if (load) begin
      c_q       <= '0;
      r_q       <= '0;
      ox_q      <= '0;
      oy_q      <= '0;
      ow_last_q <= DIM_SIZE'(32'(cfg_w) / POOL - 32'd1);
      oh_last_q <= DIM_SIZE'(32'(cfg_h) / POOL - 32'd1);
      w_q       <= MEM_SIZE'(cfg_w);
      row_q     <= cfg_src;
      win_row_q <= cfg_src;
      col_q     <= '0;
      dst_q     <= cfg_dst;
    end else if (step) begin
      if (c_q != K_LAST) begin
        c_q   <= c_q + KW'(1);
        col_q <= col_q + MEM_SIZE'(1);
      end else if (r_q != K_LAST) begin
        c_q   <= '0;
        r_q   <= r_q + KW'(1);
        col_q <= col_q - K_BACK;
        row_q <= row_q + w_q;
      end else begin
        c_q   <= '0;
        r_q   <= '0;
        dst_q <= dst_q + MEM_SIZE'(1);
        if (ox_q != ow_last_q) begin
          ox_q  <= ox_q + DIM_SIZE'(1);
          col_q <= col_q + MEM_SIZE'(1);
          row_q <= win_row_q;
        end else begin
          ox_q      <= '0;
          oy_q      <= oy_q + DIM_SIZE'(1);
          col_q     <= '0;
          row_q     <= row_q + w_q;
          win_row_q <= row_q + w_q;
        end
      end
    end
  end

endmodule

// File: rtl/maxp_ctrl.sv
// Max-pool sequencer: walks K x K windows, issues feature-memory reads and
// drives maxp_unit en/we/wa aligned with read data. Macro: MAXP_CTRL_FAIR_EN.
//
// state | meaning
// IDLE  | waiting for start
// REQ   | mem_req high, waiting for mem_gnt
// RUN   | one mem_re per cycle
// REL   | request dropped for one cycle at a row end (MAXP_CTRL_FAIR_EN only)
// DRAIN | 3 cycles letting the last window reach maxp_unit's write port
// DONE  | done pulse
module maxp_ctrl
  import maxp_ctrl_pkg::*;
#(
  parameter int POOL     = 2,
  parameter int DIM_SIZE = 8
) (
  input  logic         clk,
  input  logic         rst,
  maxp_ctrl_if.master  bus
);

  state_t              state_q, next_state;
  logic [1:0]          drain_q;
  logic                load, issue, job_empty;
  logic [MEM_SIZE-1:0] rd_addr, wr_addr;
  logic                last_elem, last_win_row, last_win;
  logic                busy_q, done_q, req_q, re_q;
  logic [MEM_SIZE-1:0] ra_q, wa_q, mp_wa_q;
  logic                bl_elem_q, bl_row_q, bl_win_q;
  logic                en_q, we_q;

  assign job_empty = (bus.cfg_w < DIM_SIZE'(POOL)) || (bus.cfg_h < DIM_SIZE'(POOL));

  maxp_addr_gen #(.POOL(POOL), .DIM_SIZE(DIM_SIZE)) u_addr_gen (
    .clk          (clk),
    .rst          (rst),
    .load         (load),
    .step         (issue),
    .cfg_src      (bus.cfg_src),
    .cfg_dst      (bus.cfg_dst),
    .cfg_w        (bus.cfg_w),
    .cfg_h        (bus.cfg_h),
    .rd_addr      (rd_addr),
    .wr_addr      (wr_addr),
    .last_elem    (last_elem),
    .last_win_row (last_win_row),
    .last_win     (last_win)
  );

  // bl_*_q describe the element currently on mem_ra, so RUN decides on the read in flight.
  always_comb begin
    next_state = state_q;
    load       = 1'b0;
    issue      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          load       = 1'b1;
          next_state = job_empty ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        if (bus.mem_gnt) begin
          issue      = 1'b1;
          next_state = S_RUN;
        end
      end
      S_RUN: begin
        if (bl_row_q && bl_win_q) next_state = S_DRAIN;
`ifdef MAXP_CTRL_FAIR_EN
        else if (bl_row_q) next_state = S_REL;
`endif
        else issue = 1'b1;
      end
`ifdef MAXP_CTRL_FAIR_EN
      S_REL:   next_state = S_REQ;
`endif
      S_DRAIN: begin
        if (drain_q == 2'd2) next_state = S_DONE;
      end
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      drain_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      req_q     <= 1'b0;
      re_q      <= 1'b0;
      ra_q      <= '0;
      wa_q      <= '0;
      bl_elem_q <= 1'b0;
      bl_row_q  <= 1'b0;
      bl_win_q  <= 1'b0;
      en_q      <= 1'b0;
      we_q      <= 1'b0;
      mp_wa_q   <= '0;
    end else begin
      state_q <= next_state;
      drain_q <= (state_q == S_DRAIN) ? drain_q + 2'd1 : 2'd0;
      busy_q  <= (next_state != S_IDLE);
      done_q  <= (next_state == S_DONE);
      req_q   <= (next_state == S_REQ) || (next_state == S_RUN);
      re_q    <= issue;
      if (issue) begin
        ra_q      <= rd_addr;
        wa_q      <= wr_addr;
        bl_elem_q <= last_elem;
        bl_row_q  <= last_win_row;
        bl_win_q  <= last_win;
      end
      en_q    <= re_q;
      we_q    <= re_q && bl_elem_q;
      mp_wa_q <= wa_q;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.mem_req = req_q;
  assign bus.mem_re  = re_q;
  assign bus.mem_ra  = ra_q;
  assign bus.mp_en   = en_q;
  assign bus.mp_we   = we_q;
  assign bus.mp_wa   = mp_wa_q;

endmodule

// File: tb/tb_maxp_ctrl.sv
// Randomized and directed jobs for maxp_ctrl checked against a loop-based
// reference of the window scan; also covers grant delay, ignored start and reset.
module tb_maxp_ctrl;
  import maxp_ctrl_pkg::*;

  localparam int POOL = 2;
  localparam int KK   = POOL * POOL;
`ifdef MAXP_CTRL_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  maxp_ctrl_if #(.DIM_SIZE(8)) bus ();

  maxp_ctrl #(.POOL(POOL), .DIM_SIZE(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // monitor state, cleared per job
  int          cyc = 0;
  logic [15:0] rd_q[$];
  bit          en_we_q[$];
  logic [15:0] en_wa_q[$];
  int          last_rd_cyc, first_rd_cyc, last_we_cyc, done_cyc, busy_fall_cyc;
  int          req_first_cyc, gnt_first_cyc;
  int          done_n, early_rd, gap_cyc, gap_runs, exp_reads;
  bit          req_seen, req_prev, busy_prev, stray_we;
  int          gnt_dly = -1;
  int          req_run = 0;

  always @(negedge clk) begin
    cyc++;
    if (bus.mem_re) begin
      if (!bus.mem_gnt) early_rd++;
      if (first_rd_cyc < 0) first_rd_cyc = cyc;
      rd_q.push_back(bus.mem_ra);
      last_rd_cyc = cyc;
    end
    if (bus.mp_en) begin
      en_we_q.push_back(bus.mp_we);
      en_wa_q.push_back(bus.mp_wa);
    end
    if (bus.mp_we) begin
      last_we_cyc = cyc;
      if (!bus.mp_en) stray_we = 1'b1;
    end
    if (bus.done) begin
      done_n++;
      done_cyc = cyc;
    end
    if (busy_prev && !bus.busy) busy_fall_cyc = cyc;
    busy_prev = bus.busy;
    if (bus.mem_req && !req_seen) req_first_cyc = cyc;
    if (bus.mem_req) req_seen = 1'b1;
    if (req_seen && !bus.mem_req && rd_q.size() < exp_reads) begin
      gap_cyc++;
      if (req_prev) gap_runs++;
    end
    req_prev = bus.mem_req;
    // arbiter model: grant after gnt_dly cycles of request, held while requested
    if (gnt_dly < 0) bus.mem_gnt = 1'b1;
    else begin
      req_run = bus.mem_req ? req_run + 1 : 0;
      bus.mem_gnt = bus.mem_req && (req_run > gnt_dly);
    end
    if (bus.mem_gnt && gnt_first_cyc < 0) gnt_first_cyc = cyc;
  end

  task automatic clear_mon();
    rd_q.delete();
    en_we_q.delete();
    en_wa_q.delete();
    last_rd_cyc = -1; first_rd_cyc = -1; last_we_cyc = -1; done_cyc = -1;
    busy_fall_cyc = -1; req_first_cyc = -1; gnt_first_cyc = -1;
    done_n = 0; early_rd = 0; gap_cyc = 0; gap_runs = 0;
    req_seen = 1'b0; req_prev = 1'b0; stray_we = 1'b0;
  endtask

  task automatic run_job(input logic [15:0] src, input logic [15:0] dst,
                         input logic [7:0] w, input logic [7:0] h,
                         input int dly, input bit poke);
    int          ow, oh, t;
    logic [15:0] exp_rd[$];
    logic [15:0] exp_wr[$];
    ow = int'(w) / POOL;
    oh = int'(h) / POOL;
    for (int oy = 0; oy < oh; oy++)
      for (int ox = 0; ox < ow; ox++) begin
        exp_wr.push_back(16'(int'(dst) + oy * ow + ox));
        for (int r = 0; r < POOL; r++)
          for (int c = 0; c < POOL; c++)
            exp_rd.push_back(16'(int'(src) + (oy * POOL + r) * int'(w) + ox * POOL + c));
      end

    @(negedge clk); #1;
    clear_mon();
    exp_reads   = exp_rd.size();
    gnt_dly     = dly;
    req_run     = 0;
    bus.cfg_src = src;
    bus.cfg_dst = dst;
    bus.cfg_w   = w;
    bus.cfg_h   = h;
    bus.start   = 1'b1;
    @(negedge clk); #1;
    bus.start = 1'b0;
    if (poke) begin
      bus.cfg_src = 16'($urandom);
      bus.cfg_dst = 16'($urandom);
      bus.cfg_w   = 8'($urandom_range(2, 12));
      bus.cfg_h   = 8'($urandom_range(2, 12));
    end
    t = 0;
    while (done_n == 0 && t < 3000) begin
      @(negedge clk); #1;
      t++;
      bus.start = (poke && t == 2);
    end
    bus.start = 1'b0;
    if (done_n == 0) chk("done_timeout", 32'(t), 32'd0);
    repeat (4) begin @(negedge clk); #1; end

    chk("done_count", done_n, 1);
    chk("busy_end", bus.busy, 1'b0);
    chk("rd_count", rd_q.size(), exp_rd.size());
    for (int i = 0; i < rd_q.size() && i < exp_rd.size(); i++) chk("rd_addr", rd_q[i], exp_rd[i]);
    chk("en_count", en_we_q.size(), exp_rd.size());
    for (int i = 0; i < en_we_q.size() && i < exp_rd.size(); i++) begin
      chk("mp_we", en_we_q[i], (i % KK) == KK - 1);
      if (en_we_q[i]) chk("mp_wa", en_wa_q[i], exp_wr[i / KK]);
    end
    chk("stray_we", stray_we, 1'b0);
    chk("rd_no_gnt", early_rd, 0);
    if (exp_rd.size() > 0) begin
      chk("we_lat", last_we_cyc - last_rd_cyc, 1);
      chk("done_lat", done_cyc - last_rd_cyc, 4);
      chk("busy_lat", busy_fall_cyc - last_rd_cyc, 5);
      chk("req_gaps", gap_cyc, FAIR ? oh - 1 : 0);
      chk("req_gap_runs", gap_runs, FAIR ? oh - 1 : 0);
      if (dly >= 0) begin
        chk("rd_after_gnt", first_rd_cyc - gnt_first_cyc, 1);
        chk("gnt_wait", first_rd_cyc - req_first_cyc, dly + 1);
      end
    end else begin
      chk("empty_req", req_seen, 1'b0);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    bus.start   = 1'b0;
    bus.cfg_src = '0;
    bus.cfg_dst = '0;
    bus.cfg_w   = '0;
    bus.cfg_h   = '0;
    bus.mem_gnt = 1'b1;
    clear_mon();
    exp_reads = 0;
    #3;
    chk("reset_ctl", {bus.busy, bus.done, bus.mem_req, bus.mem_re, bus.mp_en, bus.mp_we}, 0);
    chk("reset_addr", {bus.mem_ra, bus.mp_wa}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    run_job(16'h0010, 16'h0080, 8'd4, 8'd4, -1, 1'b0);
    run_job(16'h0010, 16'h0080, 8'd4, 8'd4, 5, 1'b0);
    run_job(16'h0010, 16'h0080, 8'd5, 8'd3, -1, 1'b0);
    run_job(16'h0010, 16'h0080, 8'd1, 8'd4, -1, 1'b0);
    run_job(16'h0010, 16'h0080, 8'd4, 8'd4, 2, 1'b1);
    run_job(16'hFFF8, 16'hFFFE, 8'd6, 8'd4, 1, 1'b0);

    for (int j = 0; j < 20; j++)
      run_job(16'($urandom), 16'($urandom), 8'($urandom_range(0, 10)), 8'($urandom_range(0, 10)),
              int'($urandom_range(0, 4)) - 1, 1'($urandom_range(0, 1)));

    // reset in the middle of a job
    @(negedge clk); #1;
    clear_mon();
    exp_reads   = 0;
    gnt_dly     = -1;
    bus.cfg_src = 16'h0100;
    bus.cfg_dst = 16'h0200;
    bus.cfg_w   = 8'd6;
    bus.cfg_h   = 8'd6;
    bus.start   = 1'b1;
    @(negedge clk); #1;
    bus.start = 1'b0;
    t = 0;
    while (rd_q.size() < 5 && t < 200) begin @(negedge clk); #1; t++; end
    chk("rst_reached_run", rd_q.size() >= 5, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_async_ctl", {bus.busy, bus.done, bus.mem_req, bus.mem_re, bus.mp_en, bus.mp_we}, 0);
    chk("rst_async_addr", {bus.mem_ra, bus.mp_wa}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (15) @(negedge clk);
    #1;
    chk("rst_no_done", done_n, 0);
    chk("rst_idle", {bus.busy, bus.mem_req, bus.mem_re}, 0);

    run_job(16'h0040, 16'h0090, 8'd4, 8'd2, -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
